// File: rtl/pipelined_carry_skip_adder_if.sv
// Valid/ready handshake bundle for pipelined_carry_skip_adder: operands in, sum/carry out.
// The master drives operands and out_ready; the slave (the adder) drives results and in_ready.
interface pipelined_carry_skip_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/pipelined_carry_skip_adder.sv
// Carry-skip adder split into STAGES register stages, each stage resolving one contiguous group
// of BLOCK-bit skip blocks. Optional macro CSA_SKIP_CNT_EN adds a saturating skip_cnt output.
module pipelined_carry_skip_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  pipelined_carry_skip_adder_if.slave bus
`ifdef CSA_SKIP_CNT_EN
  ,
  output logic [15:0]                 skip_cnt
`endif
);
  // WIDTH must divide into BLOCK-bit blocks, and the block count into STAGES equal groups.
  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;
  localparam int GW   = BPS * BLOCK;
`ifdef CSA_SKIP_CNT_EN
  localparam int SKW  = $clog2(NBLK + 1);
`endif

  typedef struct packed {
    logic [GW-1:0]  sum;
    logic           carry;
`ifdef CSA_SKIP_CNT_EN
    logic [SKW-1:0] skips;
`endif
  } grp_t;

  // One group of skip blocks: each block ripples internally, and its carry-out bypasses
  // the ripple chain whenever every bit of the block propagates.
  function automatic grp_t add_group(input logic [GW-1:0] a, input logic [GW-1:0] b,
                                     input logic c_in);
    grp_t r;
    logic c, rc, all_p, p;
    r = '0;
    c = c_in;
    for (int blk = 0; blk < BPS; blk++) begin
      rc    = c;
      all_p = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        p                      = a[blk*BLOCK+i] ^ b[blk*BLOCK+i];
        r.sum[blk*BLOCK+i]     = p ^ rc;
        rc                     = (a[blk*BLOCK+i] & b[blk*BLOCK+i]) | (p & rc);
        all_p                  = all_p & p;
      end
      c = all_p ? c : rc;
`ifdef CSA_SKIP_CNT_EN
      r.skips = r.skips + SKW'(all_p);
`endif
    end
    r.carry = c;
    return r;
  endfunction

  // Every stage moves together; a stalled output freezes the whole pipe.
  logic advance;
  assign advance = ~g_stage[STAGES-1].valid_q | bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = (k + 1) * GW;
    localparam int IN_W = WIDTH - k * GW;

    logic             valid_in, carry_in;
    logic [IN_W-1:0]  a_in, b_in;
    logic [LO-1:0]    sum_cat;
    grp_t             grp;
    logic             valid_d, valid_q, carry_d, carry_q;
    logic [LO-1:0]    sum_d, sum_q;
`ifdef CSA_SKIP_CNT_EN
    logic [SKW-1:0]   skips_in, skips_d, skips_q;
`endif

    always_comb grp = add_group(a_in[GW-1:0], b_in[GW-1:0], carry_in);

    if (k == 0) begin : g_src
      assign valid_in = bus.in_valid;
      assign carry_in = bus.cin;
      assign a_in     = bus.a;
      assign b_in     = bus.b;
      assign sum_cat  = grp.sum;
`ifdef CSA_SKIP_CNT_EN
      assign skips_in = '0;
`endif
    end else begin : g_src
      assign valid_in = g_stage[k-1].valid_q;
      assign carry_in = g_stage[k-1].carry_q;
      assign a_in     = g_stage[k-1].g_rest.a_q;
      assign b_in     = g_stage[k-1].g_rest.b_q;
      assign sum_cat  = {grp.sum, g_stage[k-1].sum_q};
`ifdef CSA_SKIP_CNT_EN
      assign skips_in = g_stage[k-1].skips_q;
`endif
    end

    // NOTE: hold values are assigned first so every path drives every output and no latch forms.
    always_comb begin
      valid_d = valid_q;
      carry_d = carry_q;
      sum_d   = sum_q;
`ifdef CSA_SKIP_CNT_EN
      skips_d = skips_q;
`endif
      if (advance) begin
        valid_d = valid_in;
        carry_d = grp.carry;
        sum_d   = sum_cat;
`ifdef CSA_SKIP_CNT_EN
        skips_d = skips_in + grp.skips;
`endif
      end
    end

    // NOTE: non-blocking assignments keep all stages sampling pre-edge values of their neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
`ifdef CSA_SKIP_CNT_EN
        skips_q <= '0;
`endif
      end else begin
        valid_q <= valid_d;
        carry_q <= carry_d;
        sum_q   <= sum_d;
`ifdef CSA_SKIP_CNT_EN
        skips_q <= skips_d;
`endif
      end
    end

    if (k < STAGES - 1) begin : g_rest
      logic [IN_W-GW-1:0] a_d, a_q, b_d, b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (advance) begin
          a_d = a_in[IN_W-1:GW];
          b_d = b_in[IN_W-1:GW];
        end
      end

      // NOTE: upper operand bits carry no reset; valid_q qualifies them, so stale data is never used.
      always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.sum       = g_stage[STAGES-1].sum_q;
  assign bus.cout      = g_stage[STAGES-1].carry_q;

`ifdef CSA_SKIP_CNT_EN
  logic [15:0] skip_cnt_d, skip_cnt_q;
  logic [16:0] skip_sum;

  always_comb begin
    skip_sum   = {1'b0, skip_cnt_q} + 17'(g_stage[STAGES-1].skips_q);
    skip_cnt_d = skip_cnt_q;
    if (bus.out_valid && bus.out_ready) begin
      skip_cnt_d = skip_sum[16] ? 16'hFFFF : skip_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) skip_cnt_q <= '0;
    else        skip_cnt_q <= skip_cnt_d;
  end

  assign skip_cnt = skip_cnt_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_skip_adder.sv
// Directed self-checking bench for pipelined_carry_skip_adder: default 32/4/2 instance plus a
// 16/4/4 instance; skip_cnt checks are compiled in only when CSA_SKIP_CNT_EN is defined.
module tb_pipelined_carry_skip_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipelined_carry_skip_adder_if #(.WIDTH(32)) bus ();
  pipelined_carry_skip_adder_if #(.WIDTH(16)) bus16 ();

`ifdef CSA_SKIP_CNT_EN
  logic [15:0] skip_cnt, skip_cnt16;
`endif

  pipelined_carry_skip_adder #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CSA_SKIP_CNT_EN
    ,
    .skip_cnt (skip_cnt)
`endif
  );

  pipelined_carry_skip_adder #(.WIDTH(16), .BLOCK(4), .STAGES(4)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
`ifdef CSA_SKIP_CNT_EN
    ,
    .skip_cnt (skip_cnt16)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h want 0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus16.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid16 got %b want 0", bus16.out_valid); end
`ifdef CSA_SKIP_CNT_EN
    checks++; if (skip_cnt !== 16'h0) begin errors++; $display("FAIL reset_skip_cnt got %h want 0", skip_cnt); end
`endif
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b want 0", bus.out_valid); end
  endtask

  // All-propagate operands: every block skips.
  task automatic test_skip();
    bus.in_valid = 1'b1; bus.a = 32'hFFFF_FFFF; bus.b = 32'h0; bus.cin = 1'b1;
    tick();
    bus.a = 32'h0F0F_0F0F; bus.b = 32'hF0F0_F0F0; bus.cin = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'h0 || bus.cout !== 1'b1) begin
      errors++; $display("FAIL skip_ones got v=%b s=%h c=%b want v=1 s=00000000 c=1", bus.out_valid, bus.sum, bus.cout); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'hFFFF_FFFF || bus.cout !== 1'b0) begin
      errors++; $display("FAIL skip_alt got v=%b s=%h c=%b want v=1 s=ffffffff c=0", bus.out_valid, bus.sum, bus.cout); end
`ifdef CSA_SKIP_CNT_EN
    checks++; if (skip_cnt !== 16'd8) begin errors++; $display("FAIL skip_cnt_first got %0d want 8", skip_cnt); end
`endif
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL skip_drain got %b want 0", bus.out_valid); end
`ifdef CSA_SKIP_CNT_EN
    checks++; if (skip_cnt !== 16'd16) begin errors++; $display("FAIL skip_cnt_second got %0d want 16", skip_cnt); end
`endif
  endtask

  task automatic test_basic();
    bus.in_valid = 1'b1; bus.a = 32'h1; bus.b = 32'h2; bus.cin = 1'b0; bus.out_ready = 1'b1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'h3 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL basic_result got v=%b s=%h c=%b want v=1 s=00000003 c=0", bus.out_valid, bus.sum, bus.cout); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [10] = '{32'h0000_0000, 32'h0000_0001, 32'h1234_5678, 32'h8000_0000, 32'h0F0F_0F0F,
                             32'h0F0F_0F0F, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'hFFFF_0000, 32'h0000_FFFF};
    logic [31:0] vb [10] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1111_1111, 32'h8000_0000, 32'hF0F0_F0F0,
                             32'hF0F0_F0F0, 32'h0000_0001, 32'h0000_0001, 32'h0001_0000, 32'h0000_0001};
    logic        vc [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [32:0] ve [10] = '{{1'b0, 32'h0000_0000}, {1'b1, 32'h0000_0000}, {1'b0, 32'h2345_6789},
                             {1'b1, 32'h0000_0001}, {1'b1, 32'h0000_0000}, {1'b0, 32'hFFFF_FFFF},
                             {1'b0, 32'h8000_0000}, {1'b0, 32'hDEAD_BEF0}, {1'b1, 32'h0000_0000},
                             {1'b0, 32'h0001_0001}};
    int got   = 0;
    int first = -1;
    int last  = -1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 10) begin
        bus.in_valid = 1'b1; bus.a = va[cyc]; bus.b = vb[cyc]; bus.cin = vc[cyc];
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d got %b want 1", cyc, bus.in_ready); end
      end else begin
        bus.in_valid = 1'b0;
      end
      tick();
      if (bus.out_valid === 1'b1) begin
        if (got < 10) begin
          checks++; if ({bus.cout, bus.sum} !== ve[got]) begin
            errors++; $display("FAIL b2b_result %0d got %h want %h", got, {bus.cout, bus.sum}, ve[got]); end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
    end
    checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count got %0d want 10", got); end
    checks++; if (first !== 1) begin errors++; $display("FAIL b2b_latency got %0d want 1", first); end
    checks++; if (last !== 10) begin errors++; $display("FAIL b2b_consecutive last got %0d want 10", last); end
  endtask

  task automatic test_stall();
    int bad_hold = 0;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 32'h0000_00FF; bus.b = 32'h0000_0001; bus.cin = 1'b0;
    tick();
    bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.cin = 1'b1;
    tick();
    bus.a = 32'h0000_0003; bus.b = 32'h0000_0004; bus.cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.sum !== 32'h0000_0100 || bus.cout !== 1'b0)
        bad_hold++;
    end
    checks++; if (bad_hold !== 0) begin
      errors++; $display("FAIL stall_hold bad cycles %0d want 0 (rdy=%b v=%b s=%h)", bad_hold, bus.in_ready, bus.out_valid, bus.sum); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'hFFFF_FFFF || bus.cout !== 1'b1) begin
      errors++; $display("FAIL stall_second got v=%b s=%h c=%b want v=1 s=ffffffff c=1", bus.out_valid, bus.sum, bus.cout); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'h0000_0008 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL stall_third got v=%b s=%h c=%b want v=1 s=00000008 c=0", bus.out_valid, bus.sum, bus.cout); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 32'h0000_0010; bus.b = 32'h0000_0020; bus.cin = 1'b0;
    tick();
    bus.a = 32'h0000_0001; bus.b = 32'h0000_0001;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== 32'h0000_0030) begin
      errors++; $display("FAIL mid_inflight got v=%b s=%h want v=1 s=00000030", bus.out_valid, bus.sum); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.sum !== 32'h0) begin
      errors++; $display("FAIL mid_async_clear got v=%b s=%h want v=0 s=0", bus.out_valid, bus.sum); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b want 1", bus.in_ready); end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL mid_stale got %0d stale cycles want 0", stale); end
  endtask

  task automatic test_w16();
    int          seen = -1;
    logic [15:0] s    = '0;
    logic        c    = 1'b0;
    bus16.out_ready = 1'b1;
    bus16.in_valid = 1'b1; bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.cin = 1'b0;
    tick();
    bus16.in_valid = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      if (seen < 0 && bus16.out_valid === 1'b1) begin
        seen = e; s = bus16.sum; c = bus16.cout;
      end
      tick();
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL w16_latency got %0d want 4", seen); end
    checks++; if (s !== 16'h0 || c !== 1'b1) begin errors++; $display("FAIL w16_result got s=%h c=%b want s=0000 c=1", s, c); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
